// File: rtl/renode_bus_arbiter.sv
// renode_bus_arbiter: round-robin arbiter sharing one Renode bus channel among local requesters.
// Optional response timeout under `RENODE_BUS_ARBITER_TIMEOUT_EN.
module renode_bus_arbiter #(
  parameter int RequestersCount = 4,
  parameter int AddressWidth = 64,
  parameter int DataWidth = 64,
  parameter int TimeoutCycles = 1024,
  localparam int GW = (RequestersCount > 1) ? $clog2(RequestersCount) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [RequestersCount-1:0]             req_valid,
  output logic [RequestersCount-1:0]             req_ready,
  input  logic [RequestersCount-1:0]             req_write,
  input  logic [RequestersCount*AddressWidth-1:0] req_address,
  input  logic [RequestersCount*DataWidth-1:0]   req_data,
  input  logic [RequestersCount*2-1:0]           req_size,
  output logic [RequestersCount-1:0]             resp_valid,
  output logic [DataWidth-1:0]                   resp_data,
  output logic                                   resp_error,
  output logic                                   fwd_valid,
  output logic                                   fwd_write,
  output logic [1:0]                             fwd_size,
  output logic [AddressWidth-1:0]                fwd_address,
  output logic [DataWidth-1:0]                   fwd_data,
  input  logic                                   fwd_ready,
  input  logic                                   fwd_resp_valid,
  input  logic                                   fwd_resp_error,
  input  logic [DataWidth-1:0]                   fwd_resp_data,
  output logic [GW-1:0]                          grant_id,
  output logic                                   busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;
  state_t state, state_nx;
  logic [GW-1:0] ptr, sel, off;
  logic [GW:0] sum;
  logic [2*RequestersCount-1:0] dbl;
  logic [RequestersCount-1:0] rot;
  logic found, timeout;
  logic sel_write;
  logic [1:0] sel_size;
  logic [AddressWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_data;
  if (RequestersCount < 1 || RequestersCount > 16 || DataWidth != 64 || TimeoutCycles < 1) begin : g_bad_params
    $error("renode_bus_arbiter: unsupported parameter set");
  end
  function automatic logic [DataWidth-1:0] size_mask(input logic [1:0] s);
    return (s == 2'd0) ? DataWidth'(8'hFF) :
           (s == 2'd1) ? DataWidth'(16'hFFFF) :
           (s == 2'd2) ? DataWidth'(32'hFFFF_FFFF) : '1;
  endfunction
  // Rotate requests so the pointer lands at bit 0; lowest set bit wins.
  always_comb begin
    dbl = {req_valid, req_valid} >> ptr;
    rot = dbl[RequestersCount-1:0];
    found = 1'b0;
    off = '0;
    for (int k = RequestersCount - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off = GW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    sel = (sum >= (GW+1)'(RequestersCount)) ? GW'(sum - (GW+1)'(RequestersCount)) : sum[GW-1:0];
  end
  always_comb begin
    sel_write = 1'b0;
    sel_size = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < RequestersCount; k++) begin
      if (sel == GW'(k)) begin
        sel_write = req_write[k];
        sel_size = req_size[k*2 +: 2];
        sel_addr = req_address[k*AddressWidth +: AddressWidth];
        sel_data = req_data[k*DataWidth +: DataWidth];
      end
    end
  end
`ifdef RENODE_BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (state == ISSUE && fwd_ready) cnt <= '0;
    else if (state == WAIT_RESP) cnt <= cnt + CW'(1);
  end
  assign timeout = (state == WAIT_RESP) && (cnt == CW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = found ? ISSUE : IDLE;
      ISSUE:     state_nx = fwd_ready ? WAIT_RESP : ISSUE;
      WAIT_RESP: state_nx = (fwd_resp_valid || timeout) ? RESPOND : WAIT_RESP;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      fwd_write <= 1'b0;
      fwd_size <= '0;
      fwd_address <= '0;
      fwd_data <= '0;
      resp_data <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        grant_id <= sel;
        ptr <= (sel == GW'(RequestersCount - 1)) ? '0 : sel + GW'(1);
        fwd_write <= sel_write;
        fwd_size <= sel_size;
        fwd_address <= sel_addr;
        fwd_data <= sel_data & size_mask(sel_size);
      end
      // A response arriving alongside the timeout takes precedence.
      if (state == WAIT_RESP && fwd_resp_valid) begin
        resp_data <= fwd_write ? '0 : fwd_resp_data & size_mask(fwd_size);
        resp_error <= fwd_resp_error;
      end else if (timeout) begin
        resp_data <= '0;
        resp_error <= 1'b1;
      end
    end
  end
  assign req_ready = (state == IDLE && found) ? RequestersCount'(1) << sel : '0;
  assign resp_valid = (state == RESPOND) ? RequestersCount'(1) << grant_id : '0;
  assign fwd_valid = (state == ISSUE);
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_renode_bus_arbiter.sv
// tb_renode_bus_arbiter: directed self-checking bench for renode_bus_arbiter (4 requesters, 64-bit).
module tb_renode_bus_arbiter;
  localparam int RC = 4;
  logic clk = 1'b0;
  logic rst;
  logic [RC-1:0] req_valid, req_ready, req_write, resp_valid;
  logic [RC*64-1:0] req_address, req_data;
  logic [RC*2-1:0] req_size;
  logic [63:0] resp_data, fwd_address, fwd_data, fwd_resp_data;
  logic resp_error, fwd_valid, fwd_write, fwd_ready, fwd_resp_valid, fwd_resp_error, busy;
  logic [1:0] fwd_size, grant_id;
  int n_chk = 0;
  int n_pass = 0;
  renode_bus_arbiter #(.RequestersCount(RC), .AddressWidth(64), .DataWidth(64), .TimeoutCycles(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data), .req_size(req_size), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_error(resp_error), .fwd_valid(fwd_valid), .fwd_write(fwd_write),
    .fwd_size(fwd_size), .fwd_address(fwd_address), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
    .fwd_resp_valid(fwd_resp_valid), .fwd_resp_error(fwd_resp_error), .fwd_resp_data(fwd_resp_data),
    .grant_id(grant_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic w, input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    req_write[i] = w;
    req_address[i*64 +: 64] = a;
    req_data[i*64 +: 64] = d;
    req_size[i*2 +: 2] = s;
  endtask
  task automatic init_reqs();
    for (int i = 0; i < RC; i++) set_req(i, 1'b0, 64'(i) << 8, 64'h0, 2'd3);
  endtask
  // Caller has driven req_valid while the arbiter is IDLE; runs one full transaction with immediate handshakes.
  task automatic xact(input int g, input logic [63:0] rdata, input logic rerr, input logic [63:0] exp_data, input logic drop);
    #1;
    chk("grant_ready", req_ready, 64'(1) << g);
    tick();
    if (drop) req_valid[g] = 1'b0;
    chk("grant_id", grant_id, 64'(g));
    chk("issue_fwd_valid", fwd_valid, 1);
    chk("issue_no_ready", req_ready, 0);
    fwd_ready = 1'b1;
    tick();
    fwd_ready = 1'b0;
    fwd_resp_valid = 1'b1;
    fwd_resp_data = rdata;
    fwd_resp_error = rerr;
    tick();
    fwd_resp_valid = 1'b0;
    chk("resp_valid", resp_valid, 64'(1) << g);
    chk("resp_data", resp_data, exp_data);
    chk("resp_error", resp_error, 64'(rerr));
    tick();
    chk("resp_valid_pulse", resp_valid, 0);
  endtask
  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_address = '0;
    req_data = '0;
    req_size = '0;
    fwd_ready = 1'b0;
    fwd_resp_valid = 1'b0;
    fwd_resp_error = 1'b0;
    fwd_resp_data = '0;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    // Read, DoubleWord, from requester 1
    set_req(1, 1'b0, 64'h1000, 64'h0, 2'd2);
    req_valid = 4'b0010;
    #1;
    chk("t1_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("t1_fwd_valid", fwd_valid, 1);
    chk("t1_fwd_addr", fwd_address, 64'h1000);
    chk("t1_fwd_size", fwd_size, 2);
    chk("t1_fwd_write", fwd_write, 0);
    chk("t1_busy", busy, 1);
    fwd_ready = 1'b1;
    tick();
    fwd_ready = 1'b0;
    chk("t1_wait_fwd_valid", fwd_valid, 0);
    fwd_resp_valid = 1'b1;
    fwd_resp_data = 64'hDEADBEEF_CAFEF00D;
    tick();
    fwd_resp_valid = 1'b0;
    chk("t1_resp_valid", resp_valid, 4'b0010);
    chk("t1_resp_data", resp_data, 64'h00000000_CAFEF00D);
    chk("t1_resp_error", resp_error, 0);
    tick();
    chk("t1_resp_pulse", resp_valid, 0);
    chk("t1_resp_hold", resp_data, 64'h00000000_CAFEF00D);
    chk("t1_idle", busy, 0);
    // Byte write from requester 0, error response, wrapping search from pointer 2
    set_req(0, 1'b1, 64'h40, 64'h1234, 2'd0);
    req_valid = 4'b0001;
    #1;
    chk("t2_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t2_fwd_data", fwd_data, 64'h34);
    chk("t2_fwd_write", fwd_write, 1);
    fwd_ready = 1'b1;
    tick();
    fwd_ready = 1'b0;
    fwd_resp_valid = 1'b1;
    fwd_resp_error = 1'b1;
    fwd_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    fwd_resp_valid = 1'b0;
    fwd_resp_error = 1'b0;
    chk("t2_resp_valid", resp_valid, 4'b0001);
    chk("t2_resp_error", resp_error, 1);
    chk("t2_resp_data", resp_data, 0);
    tick();
    // All four requesting from reset: 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    init_reqs();
    req_valid = 4'b1111;
    xact(0, 64'h1111, 1'b0, 64'h1111, 1'b0);
    xact(1, 64'h2222, 1'b0, 64'h2222, 1'b0);
    xact(2, 64'h3333, 1'b0, 64'h3333, 1'b0);
    xact(3, 64'h4444, 1'b0, 64'h4444, 1'b0);
    xact(0, 64'h5555, 1'b0, 64'h5555, 1'b0);
    // Serve 2 to park the pointer at 3, then 0 and 3 compete
    req_valid = 4'b0100;
    xact(2, 64'h6666, 1'b0, 64'h6666, 1'b1);
    req_valid = 4'b1001;
    xact(3, 64'h7777, 1'b0, 64'h7777, 1'b1);
    xact(0, 64'h8888, 1'b0, 64'h8888, 1'b1);
    // fwd_ready held off for 5 cycles
    set_req(1, 1'b1, 64'h2000, 64'hA5A5_0000_1111_2222, 2'd3);
    req_valid = 4'b0010;
    #1;
    chk("t5_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      chk("t5_stall_valid", fwd_valid, 1);
      chk("t5_stall_addr", fwd_address, 64'h2000);
      chk("t5_stall_data", fwd_data, 64'hA5A5_0000_1111_2222);
      tick();
    end
    chk("t5_hs_valid", fwd_valid, 1);
    fwd_ready = 1'b1;
    tick();
    fwd_ready = 1'b0;
    chk("t5_post_hs_valid", fwd_valid, 0);
    chk("t5_wait_busy", busy, 1);
    // Reset while waiting for the response, then a stale response arrives
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fwd_resp_valid = 1'b1;
    fwd_resp_data = 64'h9999;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_fwd_valid", fwd_valid, 0);
    chk("t6_fwd_addr", fwd_address, 0);
    chk("t6_fwd_data", fwd_data, 0);
    chk("t6_grant", grant_id, 0);
    chk("t6_resp_data", resp_data, 0);
    tick();
    fwd_resp_valid = 1'b0;
    chk("t6_late_resp_valid", resp_valid, 0);
    chk("t6_late_busy", busy, 0);
    init_reqs();
    req_valid = 4'b1001;
    xact(0, 64'hABCD, 1'b0, 64'hABCD, 1'b1);
    req_valid = '0;
`ifdef RENODE_BUS_ARBITER_TIMEOUT_EN
    req_valid = 4'b0100;
    #1;
    chk("to_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    fwd_ready = 1'b1;
    tick();
    fwd_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("to_waiting", resp_valid, 0);
      tick();
    end
    chk("to_resp_valid", resp_valid, 4'b0100);
    chk("to_resp_error", resp_error, 1);
    chk("to_resp_data", resp_data, 0);
    tick();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
